chip_stimulus_gen: RTL

Upstream stimulus stage for the chip checker. Drives the device-under-test input pins through the level translator with a selectable sequence of test vectors. Holds each vector for a programmable settle time, then issues a one-cycle `sample` strobe so the compare/count stage only evaluates settled outputs. Tracks completed passes for status display.

---
 rtl/chip_stimulus_gen_pkg.sv | 28 ++
 rtl/chip_stimulus_gen_pattern_gen.sv | 55 +++++
 rtl/chip_stimulus_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/chip_stimulus_gen_pkg.sv
// ---------------------------------------------------------------------------
// chip_stimulus_gen_pkg
// Shared definitions for the chip checker stimulus and compare/count stages:
//   - vector sequence (mode) encodings
//   - stimulus FSM state encoding
//   - saturating 8-bit increment used by the pass counter
// ---------------------------------------------------------------------------
package chip_stimulus_gen_pkg;

    // Vector sequence selection, latched when a run starts
    localparam logic [1:0] MODE_COUNT = 2'b00;  // binary count 0 .. 2^WIDTH-1
    localparam logic [1:0] MODE_WALK1 = 2'b01;  // single one walking from bit 0 upwards
    localparam logic [1:0] MODE_WALK0 = 2'b10;  // inverse of MODE_WALK1
    localparam logic [1:0] MODE_ALT   = 2'b11;  // all-zero then all-one

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Pass counter sticks at 255 so a long continuous run never wraps to a small value
    function automatic logic [7:0] satInc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/chip_stimulus_gen_pattern_gen.sv
// ---------------------------------------------------------------------------
// pattern_gen
// Combinational test-vector lookup for the stimulus generator.
// Ports:
//   mode     in  [1:0]        vector sequence selector (MODE_* encodings)
//   index    in  [WIDTH-1:0]  position within the current pass
//   vector   out [WIDTH-1:0]  pattern to drive onto the DUT inputs
//   is_last  out              index is the final vector of the pass
// ---------------------------------------------------------------------------
module pattern_gen
    import chip_stimulus_gen_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] index,
    output logic [WIDTH-1:0] vector,
    output logic             is_last
);

    logic [WIDTH-1:0] oneHot;
    logic             lastWalk;

    // The index register is WIDTH bits wide so it can cover the full binary
    // count; the walking and alternate sequences only use its low values.
    always_comb begin
        oneHot   = WIDTH'(1) << index;
        lastWalk = (index == WIDTH'(WIDTH - 1));
        vector   = '0;
        is_last  = 1'b0;
        case (mode)
            MODE_COUNT: begin
                vector  = index;
                is_last = &index;
            end
            MODE_WALK1: begin
                vector  = oneHot;
                is_last = lastWalk;
            end
            MODE_WALK0: begin
                vector  = ~oneHot;
                is_last = lastWalk;
            end
            MODE_ALT: begin
                vector  = {WIDTH{index[0]}};
                is_last = index[0];
            end
            default: begin
                vector  = '0;
                is_last = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/chip_stimulus_gen.sv
// ---------------------------------------------------------------------------
// chip_stimulus_gen
// Drives the DUT input pins (through the level translator) with a selectable
// vector sequence, holds each vector SETTLE cycles, then strobes `sample` for
// one cycle so the compare/count stage only looks at settled outputs.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             level; begins a run when idle (ignored when stop is high)
//   stop              aborts a run, back to idle with no sample/done
//   mode[1:0]         vector sequence, latched at start
//   continuous        repeat passes until stopped, latched at start
//   stim[WIDTH-1:0]   vector to the DUT inputs (0 when not running)
//   stim_oe           translator output enable while running
//   sample            one-cycle strobe, stim has been stable SETTLE cycles
//   last              with sample, final vector of the pass
//   busy              run in progress
//   done              one-cycle pulse at the end of a non-continuous run
//   pass_count[7:0]   passes completed since the last start, saturating
// ---------------------------------------------------------------------------
module chip_stimulus_gen
    import chip_stimulus_gen_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int SETTLE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic             continuous,
    output logic [WIDTH-1:0] stim,
    output logic             stim_oe,
    output logic             sample,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic [7:0]       pass_count
);

    // Counter runs SETTLE-1 .. 0, giving SETTLE cycles in ST_SETTLE
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] index_q,    index_d;
    logic [7:0]       settleCnt_q, settleCnt_d;
    logic [1:0]       modeSel_q,  modeSel_d;
    logic             cont_q,     cont_d;
    logic [7:0]       passCnt_q,  passCnt_d;

    logic [WIDTH-1:0] vecCur;
    logic             isLast;

    pattern_gen #(
        .WIDTH (WIDTH)
    ) u_pattern (
        .mode    (modeSel_q),
        .index   (index_q),
        .vector  (vecCur),
        .is_last (isLast)
    );

    // Next-state and Moore outputs. stim is forced to zero outside the
    // running states so the stale latched mode never leaks onto the pins.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        settleCnt_d = settleCnt_q;
        modeSel_d   = modeSel_q;
        cont_d      = cont_q;
        passCnt_d   = passCnt_q;
        stim        = '0;
        stim_oe     = 1'b0;
        sample      = 1'b0;
        last        = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    modeSel_d   = mode;
                    cont_d      = continuous;
                    passCnt_d   = '0;
                    index_d     = '0;
                    settleCnt_d = SETTLE_LOAD;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                stim    = vecCur;
                stim_oe = 1'b1;
                busy    = 1'b1;
                if (settleCnt_q == 8'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settleCnt_d = settleCnt_q - 8'd1;
                end
            end
            ST_SAMPLE: begin
                stim    = vecCur;
                stim_oe = 1'b1;
                busy    = 1'b1;
                sample  = 1'b1;
                last    = isLast;
                if (isLast) begin
                    passCnt_d = satInc8(passCnt_q);
                end
                if (isLast && !cont_q) begin
                    state_d = ST_DONE;
                end else begin
                    index_d     = isLast ? '0 : index_q + WIDTH'(1);
                    settleCnt_d = SETTLE_LOAD;
                    state_d     = ST_SETTLE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An aborted pass is not counted, even if stop lands on its last sample
        if (stop && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            passCnt_d = passCnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            settleCnt_q <= '0;
            modeSel_q   <= MODE_COUNT;
            cont_q      <= 1'b0;
            passCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            settleCnt_q <= settleCnt_d;
            modeSel_q   <= modeSel_d;
            cont_q      <= cont_d;
            passCnt_q   <= passCnt_d;
        end
    end

    assign pass_count = passCnt_q;

endmodule
